// File: rtl/uart_rx_deser_pkg.sv
// Shared UART definitions: receiver FSM state encoding and default line parameters.
// The matching TX block reuses these defaults.
package uart_rx_deser_pkg;

  localparam int unsigned BAUD_DEFAULT       = 19_200;
  localparam int unsigned OVERSAMPLE_DEFAULT = 16;
  localparam int unsigned DATA_BITS_DEFAULT  = 8;

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    START     = 3'd1,
    DATA      = 3'd2,
    STOP      = 3'd3,
    WAIT_HIGH = 3'd4
  } rx_state_e;

  // Bits needed to hold a count 0..n-1 (at least one bit).
  function automatic int unsigned cnt_width(input int unsigned n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/uart_rx_deser_baud_tick_gen.sv
// Free-running oversample tick: one-cycle pulse every DIVISOR clocks.
// Shared by the UART RX and TX sides.
module baud_tick_gen #(
  parameter int unsigned DIVISOR = 10
) (
  input  logic i_clk,
  input  logic i_rst,
  output logic o_tick
);

  localparam int unsigned CW = (DIVISOR <= 2) ? 1 : $clog2(DIVISOR);

  logic [CW-1:0] cnt;

  always_ff @(posedge i_clk) begin
    if (!i_rst) begin
      cnt <= '0;
    end else if (cnt == CW'(DIVISOR - 1)) begin
      cnt <= '0;
    end else begin
      cnt <= cnt + 1'b1;
    end
  end

  assign o_tick = (cnt == CW'(DIVISOR - 1));

endmodule

// File: rtl/uart_rx_deser.sv
// Oversampling 8N1 UART receiver: synchronizes the RX pin, deframes bytes,
// strobes o_rx_done on a good frame and o_frame_err on a low stop bit.
module uart_rx_deser
  import uart_rx_deser_pkg::*;
#(
  parameter int unsigned CLK_FREQ_HZ = 50_000_000,
  parameter int unsigned BAUD        = BAUD_DEFAULT,
  parameter int unsigned OVERSAMPLE  = OVERSAMPLE_DEFAULT,
  parameter int unsigned DATA_BITS   = DATA_BITS_DEFAULT,
  parameter int unsigned STOP_TICKS  = 16
) (
  input  logic                 i_clk,
  input  logic                 i_rst,
  input  logic                 i_uart_rx,
  output logic [DATA_BITS-1:0] o_data,
  output logic                 o_rx_done,
  output logic                 o_frame_err,
  output logic                 o_busy
);

  localparam int unsigned DIVISOR = CLK_FREQ_HZ / (BAUD * OVERSAMPLE);
  localparam int unsigned SMAX    = (OVERSAMPLE > STOP_TICKS) ? OVERSAMPLE : STOP_TICKS;
  localparam int unsigned SW      = cnt_width(SMAX);
  localparam int unsigned NW      = cnt_width(DATA_BITS);

  logic tick;

  baud_tick_gen #(
    .DIVISOR(DIVISOR)
  ) u_tick (
    .i_clk (i_clk),
    .i_rst (i_rst),
    .o_tick(tick)
  );

  // Two-flop synchronizer; resets to the idle-high line level.
  logic rx_meta;
  logic rx_s;

  always_ff @(posedge i_clk) begin
    if (!i_rst) begin
      rx_meta <= 1'b1;
      rx_s    <= 1'b1;
    end else begin
      rx_meta <= i_uart_rx;
      rx_s    <= rx_meta;
    end
  end

  rx_state_e            state, state_n;
  logic [SW-1:0]        s_cnt, s_cnt_n;
  logic [NW-1:0]        n_cnt, n_cnt_n;
  logic [DATA_BITS-1:0] shift, shift_n;
  logic [DATA_BITS-1:0] data_n;
  logic                 done_n;
  logic                 err_n;

  always_ff @(posedge i_clk) begin
    if (!i_rst) begin
      state       <= IDLE;
      s_cnt       <= '0;
      n_cnt       <= '0;
      shift       <= '0;
      o_data      <= '0;
      o_rx_done   <= 1'b0;
      o_frame_err <= 1'b0;
    end else begin
      state       <= state_n;
      s_cnt       <= s_cnt_n;
      n_cnt       <= n_cnt_n;
      shift       <= shift_n;
      o_data      <= data_n;
      o_rx_done   <= done_n;
      o_frame_err <= err_n;
    end
  end

  always_comb begin
    state_n = state;
    s_cnt_n = s_cnt;
    n_cnt_n = n_cnt;
    shift_n = shift;
    data_n  = o_data;
    done_n  = 1'b0;
    err_n   = 1'b0;

    case (state)
      IDLE: begin
        if (!rx_s) begin
          state_n = START;
          s_cnt_n = '0;
        end
      end

      START: begin
        if (tick) begin
          if (s_cnt == SW'(OVERSAMPLE / 2 - 1)) begin
            // Mid start bit: a high line here means the edge was a glitch.
            if (!rx_s) begin
              state_n = DATA;
              s_cnt_n = '0;
              n_cnt_n = '0;
            end else begin
              state_n = IDLE;
            end
          end else begin
            s_cnt_n = s_cnt + 1'b1;
          end
        end
      end

      DATA: begin
        if (tick) begin
          if (s_cnt == SW'(OVERSAMPLE - 1)) begin
            shift_n = {rx_s, shift[DATA_BITS-1:1]};
            s_cnt_n = '0;
            if (n_cnt == NW'(DATA_BITS - 1)) begin
              state_n = STOP;
            end else begin
              n_cnt_n = n_cnt + 1'b1;
            end
          end else begin
            s_cnt_n = s_cnt + 1'b1;
          end
        end
      end

      STOP: begin
        if (tick) begin
          if (s_cnt == SW'(STOP_TICKS - 1)) begin
            if (rx_s) begin
              data_n  = shift;
              done_n  = 1'b1;
              state_n = IDLE;
            end else begin
              err_n   = 1'b1;
              state_n = WAIT_HIGH;
            end
          end else begin
            s_cnt_n = s_cnt + 1'b1;
          end
        end
      end

      WAIT_HIGH: begin
        if (rx_s) begin
          state_n = IDLE;
        end
      end

      default: begin
        state_n = IDLE;
      end
    endcase
  end

  assign o_busy = (state != IDLE);

endmodule

// File: tb/tb_uart_rx_deser.sv
// Randomized scoreboard bench for uart_rx_deser: a serial driver pushes the
// expected frame outcome, a monitor pops and compares on every output pulse.
module tb_uart_rx_deser;

  localparam int unsigned BIT_CLKS = 160;

  logic       clk = 1'b0;
  logic       i_rst;
  logic       i_uart_rx;
  logic [7:0] o_data;
  logic       o_rx_done;
  logic       o_frame_err;
  logic       o_busy;

  always #5 clk = ~clk;

  uart_rx_deser #(
    .CLK_FREQ_HZ(3_072_000),
    .BAUD       (19_200),
    .OVERSAMPLE (16),
    .DATA_BITS  (8),
    .STOP_TICKS (16)
  ) dut (
    .i_clk      (clk),
    .i_rst      (i_rst),
    .i_uart_rx  (i_uart_rx),
    .o_data     (o_data),
    .o_rx_done  (o_rx_done),
    .o_frame_err(o_frame_err),
    .o_busy     (o_busy)
  );

  typedef struct packed {
    logic       err;
    logic [7:0] data;
  } exp_t;

  exp_t        exp_q[$];
  exp_t        e;
  int unsigned tests = 0;
  int unsigned fails = 0;
  logic [7:0]  model_data = 8'h00;
  logic        prev_pulse = 1'b0;
  bit          mon_en = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Inputs change 2 time units after a rising edge; checks run on falling edges.
  task automatic cyc(input int unsigned n);
    repeat (n) @(posedge clk);
    #2;
  endtask

  task automatic send_frame(input logic [7:0] b, input logic stop, input int unsigned bclk);
    i_uart_rx = 1'b0;
    cyc(bclk);
    for (int i = 0; i < 8; i++) begin
      i_uart_rx = b[i];
      cyc(bclk);
    end
    i_uart_rx = stop;
    cyc(bclk);
  endtask

  task automatic good_frame(input logic [7:0] b, input int unsigned bclk);
    exp_q.push_back('{err: 1'b0, data: b});
    send_frame(b, 1'b1, bclk);
  endtask

  task automatic drain(input int unsigned budget);
    for (int unsigned c = 0; c < budget && exp_q.size() != 0; c++) cyc(1);
    check("drain_pending", exp_q.size(), 0);
  endtask

  // Monitor: every pulse must match the head of the expectation queue.
  always @(negedge clk) begin
    if (mon_en) begin
      if (i_rst === 1'b0) model_data = 8'h00;
      if (o_rx_done === 1'b1 || o_frame_err === 1'b1) begin
        check("pulse_exclusive", o_rx_done & o_frame_err, 0);
        check("pulse_width", prev_pulse, 0);
        check("pulse_expected", exp_q.size() != 0, 1);
        if (exp_q.size() != 0) begin
          e = exp_q.pop_front();
          check("pulse_kind_err", o_frame_err, e.err);
          if (!e.err) begin
            check("rx_data", o_data, e.data);
            model_data = e.data;
          end else begin
            check("data_held_on_err", o_data, model_data);
          end
        end
      end
      prev_pulse = o_rx_done | o_frame_err;
    end
  end

  initial begin
    repeat (150_000) @(posedge clk);
    $display("FAIL watchdog: simulation exceeded cycle budget");
    $fatal(1, "watchdog");
  end

  initial begin
    int unsigned bclk;
    logic [7:0]  b;

    i_rst     = 1'b0;
    i_uart_rx = 1'b1;
    cyc(5);
    check("reset_data", o_data, 0);
    check("reset_done", o_rx_done, 0);
    check("reset_err", o_frame_err, 0);
    check("reset_busy", o_busy, 0);
    i_rst  = 1'b1;
    mon_en = 1'b1;
    cyc(20);

    // Single clean frame
    good_frame(8'hA5, BIT_CLKS);
    cyc(BIT_CLKS);
    drain(2000);
    check("t1_data", o_data, 8'hA5);

    // Short low glitch must not start a frame
    i_uart_rx = 1'b0;
    cyc(50);
    i_uart_rx = 1'b1;
    cyc(200);
    check("glitch_busy", o_busy, 0);
    check("glitch_data", o_data, 8'hA5);
    good_frame(8'h3C, BIT_CLKS);
    cyc(BIT_CLKS);

    // Low stop bit followed by a long break
    exp_q.push_back('{err: 1'b1, data: 8'h00});
    send_frame(8'h3C, 1'b0, BIT_CLKS);
    cyc(BIT_CLKS * 10);
    check("break_busy", o_busy, 1);
    cyc(BIT_CLKS * 10);
    i_uart_rx = 1'b1;
    cyc(BIT_CLKS);
    check("break_idle", o_busy, 0);
    check("break_data_kept", o_data, model_data);
    good_frame(8'h55, BIT_CLKS);
    cyc(BIT_CLKS);
    drain(2000);

    // Reset mid-frame during data bit 4 of 0xFF
    i_uart_rx = 1'b0;
    cyc(BIT_CLKS);
    i_uart_rx = 1'b1;
    cyc(BIT_CLKS * 4 + BIT_CLKS / 2);
    check("midframe_busy", o_busy, 1);
    i_rst = 1'b0;
    cyc(1);
    i_rst = 1'b1;
    check("rst_abort_data", o_data, 0);
    check("rst_abort_busy", o_busy, 0);
    cyc(BIT_CLKS * 4 + BIT_CLKS);
    good_frame(8'h0F, BIT_CLKS);
    cyc(BIT_CLKS);
    drain(2000);
    check("after_rst_data", o_data, 8'h0F);

    // Back-to-back frames with no idle gap
    good_frame(8'h00, BIT_CLKS);
    good_frame(8'hFF, BIT_CLKS);
    good_frame(8'h81, BIT_CLKS);
    cyc(BIT_CLKS);
    drain(2000);

    // +/-3% baud skew
    good_frame(8'h5A, 165);
    cyc(BIT_CLKS);
    good_frame(8'h5A, 155);
    cyc(BIT_CLKS);
    drain(2000);

    // Randomized frames, skew, gaps and occasional bad stop bits
    for (int n = 0; n < 20; n++) begin
      b    = 8'($urandom);
      bclk = (BIT_CLKS * (97 + $urandom_range(0, 6)) + 50) / 100;
      if ($urandom_range(0, 5) == 0) begin
        exp_q.push_back('{err: 1'b1, data: 8'h00});
        send_frame(b, 1'b0, bclk);
        cyc(bclk * $urandom_range(1, 3));
        i_uart_rx = 1'b1;
        cyc(bclk);
      end else begin
        good_frame(b, bclk);
        i_uart_rx = 1'b1;
        cyc($urandom_range(0, 320));
      end
    end
    cyc(BIT_CLKS);
    drain(2000);
    check("final_data", o_data, model_data);
    check("final_busy", o_busy, 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
